// File: rtl/lsu_pkg.sv
// Shared types and dtype helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    DtB   = 3'b000,
    DtH   = 3'b001,
    DtW   = 3'b010,
    DtBu  = 3'b011,
    DtHu  = 3'b100,
    DtD   = 3'b101,
    DtWu  = 3'b110,
    DtIll = 3'b111
  } dtype_e;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StBeat0 = 3'd1;
  localparam logic [2:0] StBeat1 = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  function automatic int unsigned size_of(input logic [2:0] dt);
    case (dtype_e'(dt))
      DtB, DtBu: return 1;
      DtH, DtHu: return 2;
      DtW, DtWu: return 4;
      DtD:       return 8;
      default:   return 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] dt, input int unsigned dw);
    case (dtype_e'(dt))
      DtD, DtWu: return dw == 64;
      DtIll:     return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic is_signed(input logic [2:0] dt);
    case (dtype_e'(dt))
      DtB, DtH, DtW: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store rotate, two-beat byte enables, load reassembly and extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB = DATA_WIDTH / 8,
  localparam int unsigned OFS = $clog2(NB)
) (
  input  logic [OFS-1:0]        ofs_i,
  input  logic [2:0]            dtype_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rd0_i,
  input  logic [DATA_WIDTH-1:0] rd1_i,
  output logic [NB-1:0]         be0_o,
  output logic [NB-1:0]         be1_o,
  output logic [DATA_WIDTH-1:0] wdata0_o,
  output logic [DATA_WIDTH-1:0] wdata1_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned LIW = $clog2(2 * NB);
  localparam int unsigned BIW = $clog2(2 * DATA_WIDTH);
  localparam int unsigned OBW = $clog2(DATA_WIDTH);

  logic [2*NB-1:0]         lanes;
  logic [2*DATA_WIDTH-1:0] wide_w;
  logic [2*DATA_WIDTH-1:0] wide_r;
  logic [LIW-1:0]          li;
  logic [BIW-1:0]          bi;
  logic [OBW-1:0]          ob;
  logic                    ext;
  int unsigned             sz;
  int unsigned             o;

  // Both beats are treated as one double-width window; beat 1 is simply the upper half.
  always_comb begin
    sz      = size_of(dtype_i);
    o       = 32'(ofs_i);
    lanes   = '0;
    wide_w  = '0;
    wide_r  = {rd1_i, rd0_i};
    rdata_o = '0;
    ext     = 1'b0;
    li      = '0;
    bi      = '0;
    ob      = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      li = LIW'(o + b);
      bi = BIW'(8 * (o + b));
      ob = OBW'(8 * b);
      if (b < sz) begin
        lanes[li]        = 1'b1;
        wide_w[bi +: 8]  = wdata_i[ob +: 8];
        rdata_o[ob +: 8] = wide_r[bi +: 8];
      end
      if (b + 1 == sz) ext = is_signed(dtype_i) & wide_r[bi + BIW'(7)];
    end
    for (int unsigned b = 0; b < NB; b++) begin
      ob = OBW'(8 * b);
      if (b >= sz) rdata_o[ob +: 8] = {8{ext}};
    end
  end

  assign be0_o    = lanes[NB-1:0];
  assign be1_o    = lanes[2*NB-1:NB];
  assign wdata0_o = wide_w[DATA_WIDTH-1:0];
  assign wdata1_o = wide_w[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/lsu_pipelined.sv
// Load/store unit: one outstanding request, one or two RAM beats, held response.
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned SPLIT_MISALIGNED = 1,
  localparam int unsigned NB = DATA_WIDTH / 8,
  localparam int unsigned OFS = $clog2(NB),
  localparam int unsigned WAW = ADDR_WIDTH - OFS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_dtype_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [WAW-1:0]        mem_addr_o,
  output logic [NB-1:0]         mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [2:0]            dtype_q, dtype_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_legal, req_cross, cur_cross, in_b0, in_b1;
  logic [WAW-1:0]        wa;
  logic [NB-1:0]         be0, be1;
  logic [DATA_WIDTH-1:0] wd0, wd1, align_rdata, align_rd0;

  assign req_legal = is_legal(req_dtype_i, DATA_WIDTH);
  assign req_cross = (32'(req_addr_i[OFS-1:0]) + size_of(req_dtype_i)) > NB;
  assign cur_cross = (32'(addr_q[OFS-1:0]) + size_of(dtype_q)) > NB;
  assign wa        = addr_q[ADDR_WIDTH-1:OFS];
  // Single-beat loads see their data live in WAIT; split loads use the beat-0 capture.
  assign align_rd0 = cur_cross ? rd0_q : mem_rdata_i;

  lsu_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .ofs_i   (addr_q[OFS-1:0]),
    .dtype_i (dtype_q),
    .wdata_i (wdata_q),
    .rd0_i   (align_rd0),
    .rd1_i   (mem_rdata_i),
    .be0_o   (be0),
    .be1_o   (be1),
    .wdata0_o(wd0),
    .wdata1_o(wd1),
    .rdata_o (align_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    dtype_d = dtype_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          dtype_d = req_dtype_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          if (!req_legal || (req_cross && SPLIT_MISALIGNED == 0)) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StBeat0;
          end
        end
      end
      StBeat0: state_d = cur_cross ? StBeat1 : StWait;
      StBeat1: begin
        rd0_d   = mem_rdata_i;
        state_d = StWait;
      end
      StWait: begin
        rdata_d = we_q ? '0 : align_rdata;
        state_d = StResp;
      end
      StResp: if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      dtype_q <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      dtype_q <= dtype_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    in_b0       = state_q == StBeat0;
    in_b1       = state_q == StBeat1;
    // Gated by reset so ready is low for the whole time reset is held.
    req_ready_o = (state_q == StIdle) && !reset;
    rsp_valid_o = state_q == StResp;
    rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    rsp_err_o   = rsp_valid_o & err_q;
    mem_en_o    = in_b0 | in_b1;
    mem_we_o    = mem_en_o & we_q;
    mem_addr_o  = in_b0 ? wa : (in_b1 ? wa + 1'b1 : '0);
    mem_be_o    = in_b0 ? be0 : (in_b1 ? be1 : '0);
    mem_wdata_o = !we_q ? '0 : (in_b0 ? wd0 : (in_b1 ? wd1 : '0));
  end

endmodule

// File: tb/tb_lsu_pipelined.sv
// Bench for lsu_pipelined: vector table, reset corner, random vs byte-level memory model.
module tb_lsu_pipelined;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Main DUT: 32-bit, split misaligned
  logic        req_valid, req_we, rsp_ready;
  logic [11:0] req_addr;
  logic [2:0]  req_dtype;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;

  lsu_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .SPLIT_MISALIGNED(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_dtype_i(req_dtype), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  // Second DUT: misaligned accesses fault; RAM returns a constant word
  logic        ns_req_valid, ns_rsp_ready, ns_req_ready, ns_rsp_valid, ns_rsp_err;
  logic        ns_mem_en, ns_mem_we;
  logic [11:0] ns_addr;
  logic [2:0]  ns_dtype;
  logic [31:0] ns_rsp_rdata, ns_mem_wdata;
  logic [31:0] ns_mem_rdata = 32'h1234_5678;
  logic [31:0] ns_wdata = 32'h0;
  logic [9:0]  ns_mem_addr;
  logic [3:0]  ns_mem_be;

  lsu_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .SPLIT_MISALIGNED(0)) u_ns (
    .clk(clk), .reset(reset),
    .req_valid_i(ns_req_valid), .req_ready_o(ns_req_ready), .req_addr_i(ns_addr),
    .req_we_i(1'b0), .req_dtype_i(ns_dtype), .req_wdata_i(ns_wdata),
    .rsp_valid_o(ns_rsp_valid), .rsp_ready_i(ns_rsp_ready), .rsp_rdata_o(ns_rsp_rdata),
    .rsp_err_o(ns_rsp_err), .mem_en_o(ns_mem_en), .mem_we_o(ns_mem_we),
    .mem_addr_o(ns_mem_addr), .mem_be_o(ns_mem_be), .mem_wdata_o(ns_mem_wdata),
    .mem_rdata_i(ns_mem_rdata)
  );

  // Third DUT: 64-bit data path
  logic        d_req_valid, d_we, d_rsp_ready, d_req_ready, d_rsp_valid, d_rsp_err;
  logic        d_mem_en, d_mem_we;
  logic [11:0] d_addr;
  logic [2:0]  d_dtype;
  logic [63:0] d_wdata, d_rsp_rdata, d_mem_wdata, d_mem_rdata;
  logic [8:0]  d_mem_addr;
  logic [7:0]  d_mem_be;

  lsu_pipelined #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .SPLIT_MISALIGNED(1)) u_d64 (
    .clk(clk), .reset(reset),
    .req_valid_i(d_req_valid), .req_ready_o(d_req_ready), .req_addr_i(d_addr),
    .req_we_i(d_we), .req_dtype_i(d_dtype), .req_wdata_i(d_wdata),
    .rsp_valid_o(d_rsp_valid), .rsp_ready_i(d_rsp_ready), .rsp_rdata_o(d_rsp_rdata),
    .rsp_err_o(d_rsp_err), .mem_en_o(d_mem_en), .mem_we_o(d_mem_we),
    .mem_addr_o(d_mem_addr), .mem_be_o(d_mem_be), .mem_wdata_o(d_mem_wdata),
    .mem_rdata_i(d_mem_rdata)
  );

  logic [63:0] ram64 [512];
  always @(posedge clk) begin
    if (d_mem_en) begin
      for (int b = 0; b < 8; b++)
        if (d_mem_we && d_mem_be[b]) ram64[d_mem_addr][8*b +: 8] <= d_mem_wdata[8*b +: 8];
      d_mem_rdata <= ram64[d_mem_addr];
    end
  end

  // Reference memory, byte addressed
  logic [7:0] ref_mem [4096];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected result of one request at DATA_WIDTH=32, split enabled.
  task automatic model(input logic [11:0] a, input logic we, input logic [2:0] dt,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    int s;
    logic [63:0] v;
    s  = (dt == 0 || dt == 3) ? 1 : (dt == 1 || dt == 4) ? 2 : (dt == 2) ? 4 : 0;
    er = (s == 0);
    rd = 32'h0;
    if (er) lat = 1;
    else lat = ((int'(a) % 4) + s > 4) ? 4 : 3;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < s; i++) ref_mem[(int'(a) + i) % 4096] = wd[8*i +: 8];
      end else begin
        v = 64'h0;
        for (int i = 0; i < s; i++) v = v | (64'(ref_mem[(int'(a) + i) % 4096]) << (8 * i));
        if (dt <= 2 && v[8*s-1]) v = v | (~64'h0 << (8 * s));
        rd = v[31:0];
      end
    end
  endtask

  logic [9:0]  bt_wa [2];
  logic [3:0]  bt_be [2];
  logic [31:0] bt_wd [2];
  int          nbeats;

  task automatic do_req(input logic [11:0] a, input logic we, input logic [2:0] dt,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd,
                        output logic er, output int lat);
    logic [31:0] held;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_dtype = dt; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom();
    lat = 1; nbeats = 0;
    while (!rsp_valid && lat < 20) begin
      if (mem_en) begin
        if (nbeats < 2) begin
          bt_wa[nbeats] = mem_addr; bt_be[nbeats] = mem_be; bt_wd[nbeats] = mem_wdata;
        end
        nbeats++;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_timeout", 64'(rsp_valid), 64'd1);
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_mem_en", 64'(mem_en), 64'd0);
      @(posedge clk); #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rdata", 64'(rsp_rdata), 64'(held));
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_ns(input string nm, input logic [11:0] a, input logic [2:0] dt,
                       input logic [31:0] erd, input logic eer, input int elat);
    int lat;
    logic saw_en;
    @(negedge clk);
    ns_req_valid = 1'b1; ns_addr = a; ns_dtype = dt;
    @(posedge clk); #1;
    ns_req_valid = 1'b0; lat = 1; saw_en = 1'b0;
    while (!ns_rsp_valid && lat < 20) begin
      saw_en = saw_en | ns_mem_en;
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, 64'(lat), 64'(elat));
    check({nm, "_err"}, 64'(ns_rsp_err), 64'(eer));
    check({nm, "_rdata"}, 64'(ns_rsp_rdata), 64'(erd));
    if (eer) check({nm, "_no_mem_en"}, 64'(saw_en), 64'd0);
    ns_rsp_ready = 1'b1;
    @(posedge clk); #1;
    ns_rsp_ready = 1'b0;
  endtask

  task automatic do64(input string nm, input logic [11:0] a, input logic we,
                      input logic [2:0] dt, input logic [63:0] wd, input logic [63:0] erd,
                      input logic eer);
    int lat;
    @(negedge clk);
    d_req_valid = 1'b1; d_addr = a; d_we = we; d_dtype = dt; d_wdata = wd;
    @(posedge clk); #1;
    d_req_valid = 1'b0; lat = 1;
    while (!d_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_valid"}, 64'(d_rsp_valid), 64'd1);
    check({nm, "_rdata"}, d_rsp_rdata, erd);
    check({nm, "_err"}, 64'(d_rsp_err), 64'(eer));
    d_rsp_ready = 1'b1;
    @(posedge clk); #1;
    d_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [11:0] a;
    logic        we;
    logic [2:0]  dt;
    logic [31:0] wd;
    int          hold;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nb;
    logic [9:0]  wa0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [9:0]  wa1;
    logic [3:0]  be1;
    logic [31:0] wd1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd, word;
    logic        er, eer;
    int          lat, elat;
    logic [11:0] a;
    logic        we;
    logic [2:0]  dt;
    logic [31:0] wd;

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    for (int i = 0; i < 512; i++) ram64[i] = 64'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    mem_rdata = 32'h0; d_mem_rdata = 64'h0;
    req_valid = 0; req_we = 0; req_addr = 0; req_dtype = 0; req_wdata = 0; rsp_ready = 0;
    ns_req_valid = 0; ns_addr = 0; ns_dtype = 0; ns_rsp_ready = 0;
    d_req_valid = 0; d_we = 0; d_addr = 0; d_dtype = 0; d_wdata = 0; d_rsp_ready = 0;
    reset = 1'b1;

    //              a       we dt  wd            hold rd            er lat nb wa0 be0 wd0 wa1 be1 wd1
    tbl.push_back('{12'h010, 1, 2, 32'hDEADBEEF, 0, 32'h0,        0, 3, 1, 10'h004, 4'hF, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{12'h010, 0, 2, 32'h0,        5, 32'hDEADBEEF, 0, 3, 1, 10'h004, 4'hF, 32'h0, 0, 0, 0});
    tbl.push_back('{12'h010, 1, 2, 32'h80FF1234, 0, 32'h0,        0, 3, 1, 10'h004, 4'hF, 32'h80FF1234, 0, 0, 0});
    tbl.push_back('{12'h013, 0, 0, 32'h0,        0, 32'hFFFFFF80, 0, 3, 1, 10'h004, 4'h8, 32'h0, 0, 0, 0});
    tbl.push_back('{12'h013, 0, 3, 32'h0,        0, 32'h00000080, 0, 3, 1, 10'h004, 4'h8, 32'h0, 0, 0, 0});
    tbl.push_back('{12'h012, 0, 1, 32'h0,        0, 32'hFFFF80FF, 0, 3, 1, 10'h004, 4'hC, 32'h0, 0, 0, 0});
    tbl.push_back('{12'h012, 0, 4, 32'h0,        0, 32'h000080FF, 0, 3, 1, 10'h004, 4'hC, 32'h0, 0, 0, 0});
    tbl.push_back('{12'h013, 1, 1, 32'hFFFFA55A, 0, 32'h0,        0, 4, 2, 10'h004, 4'h8, 32'h5A000000, 10'h005, 4'h1, 32'h000000A5});
    tbl.push_back('{12'h013, 0, 1, 32'h0,        2, 32'hFFFFA55A, 0, 4, 2, 10'h004, 4'h8, 32'h0, 10'h005, 4'h1, 32'h0});
    tbl.push_back('{12'hFFC, 1, 2, 32'h11223344, 0, 32'h0,        0, 3, 1, 10'h3FF, 4'hF, 32'h11223344, 0, 0, 0});
    tbl.push_back('{12'h000, 1, 2, 32'h55667788, 0, 32'h0,        0, 3, 1, 10'h000, 4'hF, 32'h55667788, 0, 0, 0});
    tbl.push_back('{12'hFFE, 0, 2, 32'h0,        0, 32'h77881122, 0, 4, 2, 10'h3FF, 4'hC, 32'h0, 10'h000, 4'h3, 32'h0});
    tbl.push_back('{12'h020, 0, 5, 32'h0,        0, 32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{12'h020, 1, 7, 32'h123,      1, 32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{12'h020, 0, 6, 32'h0,        0, 32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{12'h021, 1, 0, 32'hFFFFFFAB, 0, 32'h0,        0, 3, 1, 10'h008, 4'h2, 32'h0000AB00, 0, 0, 0});
    tbl.push_back('{12'h021, 0, 3, 32'h0,        0, 32'h000000AB, 0, 3, 1, 10'h008, 4'h2, 32'h0, 0, 0, 0});
    tbl.push_back('{12'h022, 1, 2, 32'h01020304, 0, 32'h0,        0, 4, 2, 10'h008, 4'hC, 32'h03040000, 10'h009, 4'h3, 32'h00000102});
    tbl.push_back('{12'h022, 0, 2, 32'h0,        0, 32'h01020304, 0, 4, 2, 10'h008, 4'hC, 32'h0, 10'h009, 4'h3, 32'h0});

    // Reset state
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_ready", 64'(req_ready), 64'd1);

    foreach (tbl[i]) begin
      model(tbl[i].a, tbl[i].we, tbl[i].dt, tbl[i].wd, erd, eer, elat);
      do_req(tbl[i].a, tbl[i].we, tbl[i].dt, tbl[i].wd, tbl[i].hold, rd, er, lat);
      check($sformatf("t%0d_rdata", i), 64'(rd), 64'(tbl[i].rd));
      check($sformatf("t%0d_err", i), 64'(er), 64'(tbl[i].er));
      check($sformatf("t%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("t%0d_nbeats", i), 64'(nbeats), 64'(tbl[i].nb));
      if (tbl[i].nb > 0) begin
        check($sformatf("t%0d_wa0", i), 64'(bt_wa[0]), 64'(tbl[i].wa0));
        check($sformatf("t%0d_be0", i), 64'(bt_be[0]), 64'(tbl[i].be0));
        check($sformatf("t%0d_wd0", i), 64'(bt_wd[0]), 64'(tbl[i].wd0));
      end
      if (tbl[i].nb > 1) begin
        check($sformatf("t%0d_wa1", i), 64'(bt_wa[1]), 64'(tbl[i].wa1));
        check($sformatf("t%0d_be1", i), 64'(bt_be[1]), 64'(tbl[i].be1));
        check($sformatf("t%0d_wd1", i), 64'(bt_wd[1]), 64'(tbl[i].wd1));
      end
    end

    // Reset during beat 1 of a split store: beat 0 stays, beat 1 never lands
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h102; req_we = 1'b1; req_dtype = 3'd2;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rb_beat0_en", 64'(mem_en), 64'd1);
    @(posedge clk); #1;
    check("rb_beat1_en", 64'(mem_en), 64'd1);
    check("rb_beat1_addr", 64'(mem_addr), 64'h41);
    reset = 1'b1;
    #1;
    check("rb_en_drop", 64'(mem_en), 64'd0);
    check("rb_valid_drop", 64'(rsp_valid), 64'd0);
    check("rb_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rb_ready_after", 64'(req_ready), 64'd1);
    check("rb_ram_beat0", 64'(ram[10'h040]), 64'hF00D0000);
    check("rb_ram_beat1", 64'(ram[10'h041]), 64'h0);
    ref_mem[12'h102] = 8'h0D;
    ref_mem[12'h103] = 8'hF0;

    // Random traffic, low region plus the wrap-around top words
    for (int n = 0; n < 150; n++) begin
      a  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 47))
                                       : 12'($urandom_range(12'hFF0, 12'hFFF));
      we = 1'($urandom_range(0, 1));
      dt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wd = $urandom();
      model(a, we, dt, wd, erd, eer, elat);
      do_req(a, we, dt, wd, int'($urandom_range(0, 2)), rd, er, lat);
      check($sformatf("r%0d_rdata a=%0h dt=%0d we=%0d", n, a, dt, we), 64'(rd), 64'(erd));
      check($sformatf("r%0d_err", n), 64'(er), 64'(eer));
      check($sformatf("r%0d_lat", n), 64'(lat), 64'(elat));
    end

    // RAM contents against reference bytes
    for (int w = 0; w < 1024; w++) begin
      if (w < 16 || w >= 1020 || w == 64 || w == 65) begin
        for (int b = 0; b < 4; b++) word[8*b +: 8] = ref_mem[4*w + b];
        check($sformatf("ram_word_%0h", w), 64'(ram[w]), 64'(word));
      end
    end

    // Faulting-misalignment instance
    do_ns("ns_lw_mis", 12'h011, 3'd2, 32'h0, 1'b1, 1);
    do_ns("ns_lw_ok", 12'h010, 3'd2, 32'h12345678, 1'b0, 3);
    do_ns("ns_lh_mis", 12'h013, 3'd1, 32'h0, 1'b1, 1);
    do_ns("ns_lb", 12'h013, 3'd0, 32'h00000012, 1'b0, 3);
    do_ns("ns_lh", 12'h012, 3'd1, 32'h00001234, 1'b0, 3);
    do_ns("ns_d", 12'h010, 3'd5, 32'h0, 1'b1, 1);

    // 64-bit instance
    do64("d_sd", 12'h008, 1'b1, 3'd5, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    do64("d_lwu", 12'h00C, 1'b0, 3'd6, 64'h0, 64'h0000000001234567, 1'b0);
    do64("d_lw", 12'h00C, 1'b0, 3'd2, 64'h0, 64'h0000000001234567, 1'b0);
    do64("d_sw", 12'h008, 1'b1, 3'd2, 64'h80000000, 64'h0, 1'b0);
    do64("d_lw_neg", 12'h008, 1'b0, 3'd2, 64'h0, 64'hFFFFFFFF80000000, 1'b0);
    do64("d_ld", 12'h008, 1'b0, 3'd5, 64'h0, 64'h0123456780000000, 1'b0);
    do64("d_lhu", 12'h00E, 1'b0, 3'd4, 64'h0, 64'h0000000000000123, 1'b0);
    do64("d_lw_split", 12'h00E, 1'b0, 3'd2, 64'h0, 64'h0000000000000123, 1'b0);
    do64("d_ill", 12'h008, 1'b0, 3'd7, 64'h0, 64'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
